// File: rtl/cw_packet_merge_arbiter.sv
// Merges the forwarded and local packet streams into the single outgoing Aurora stream.
// Each source owns a packet FIFO; whole committed packets are granted round-robin.
module cw_packet_merge_arbiter #(
    parameter int ADDR_WIDTH       = 6,
    parameter int DROP_COUNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic [15:0]                 forwardedTDATA,
    input  logic                        forwardedTVALID,
    input  logic                        forwardedTLAST,
    input  logic [15:0]                 localTDATA,
    input  logic                        localTVALID,
    input  logic                        localTLAST,
    output logic [15:0]                 mergedTDATA,
    output logic                        mergedTVALID,
    output logic                        mergedTLAST,
    input  logic                        mergedTREADY,
    output logic [DROP_COUNT_WIDTH-1:0] forwardedDropCount,
    output logic [DROP_COUNT_WIDTH-1:0] localDropCount
);
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int SRC_FWD   = 0;
    localparam int SRC_LOCAL = 1;

    typedef enum logic [1:0] {IDLE, SEND_FWD, SEND_LOCAL} state_t;

    logic [15:0]                 w_in_data    [2];
    logic [15:0]                 w_head_data  [2];
    logic [DROP_COUNT_WIDTH-1:0] w_drop_count [2];
    logic [1:0]                  w_in_valid;
    logic [1:0]                  w_in_last;
    logic [1:0]                  w_pop;
    logic [1:0]                  w_has_pkt;
    logic [1:0]                  w_head_last;

    assign w_in_data[SRC_FWD]   = forwardedTDATA;
    assign w_in_data[SRC_LOCAL] = localTDATA;
    assign w_in_valid           = {localTVALID, forwardedTVALID};
    assign w_in_last            = {localTLAST, forwardedTLAST};

    for (genvar s = 0; s < 2; s++) begin : g_fifo
        logic [16:0]                 r_mem [DEPTH];
        logic [ADDR_WIDTH:0]         r_wp;
        logic [ADDR_WIDTH:0]         r_cp;
        logic [ADDR_WIDTH:0]         r_rp;
        logic [ADDR_WIDTH:0]         r_pkt_count;
        logic                        r_discard;
        logic [DROP_COUNT_WIDTH-1:0] r_drop_count;
        logic                        w_full;
        logic                        w_write;
        logic                        w_overflow;
        logic                        w_commit;
        logic                        w_pop_last;

        // Fullness counts uncommitted words and uses pre-cycle pointers only.
        assign w_full      = (r_wp - r_rp) == {1'b1, {ADDR_WIDTH{1'b0}}};
        assign w_write     = w_in_valid[s] && !w_full && !r_discard;
        assign w_overflow  = w_in_valid[s] && w_full && !r_discard;
        assign w_commit    = w_write && w_in_last[s];
        assign w_head_data[s] = r_mem[r_rp[ADDR_WIDTH-1:0]][15:0];
        assign w_head_last[s] = r_mem[r_rp[ADDR_WIDTH-1:0]][16];
        assign w_pop_last  = w_pop[s] && w_head_last[s];

        // NOTE: the storage array has no reset; pointers alone define what is valid.
        always_ff @(posedge clk) begin
            if (w_write) begin
                r_mem[r_wp[ADDR_WIDTH-1:0]] <= {w_in_last[s], w_in_data[s]};
            end
        end

        // NOTE: all clocked state uses non-blocking assignments so every process sees pre-edge values.
        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                r_wp         <= '0;
                r_cp         <= '0;
                r_rp         <= '0;
                r_pkt_count  <= '0;
                r_discard    <= 1'b0;
                r_drop_count <= '0;
            end else begin
                if (w_write) begin
                    r_wp <= r_wp + 1'b1;
                end else if (w_overflow) begin
                    r_wp <= r_cp;
                end
                if (w_commit) begin
                    r_cp <= r_wp + 1'b1;
                end
                // An overflowing TLAST beat ends the packet, so no discard phase follows it.
                if (w_overflow) begin
                    r_discard <= !w_in_last[s];
                end else if (r_discard && w_in_valid[s] && w_in_last[s]) begin
                    r_discard <= 1'b0;
                end
                if (w_overflow && (r_drop_count != '1)) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
                if (w_pop[s]) begin
                    r_rp <= r_rp + 1'b1;
                end
                if (w_commit && !w_pop_last) begin
                    r_pkt_count <= r_pkt_count + 1'b1;
                end else if (w_pop_last && !w_commit) begin
                    r_pkt_count <= r_pkt_count - 1'b1;
                end
            end
        end

        assign w_has_pkt[s]    = r_pkt_count != '0;
        assign w_drop_count[s] = r_drop_count;
    end

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last_grant_local;
    logic        r_valid;
    logic        r_last;
    logic [15:0] r_data;
    logic        w_accept;

    assign w_accept = r_valid && mergedTREADY;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pop        = '0;
        case (r_state)
            IDLE: begin
                if (w_has_pkt[SRC_FWD] && (!w_has_pkt[SRC_LOCAL] || r_last_grant_local)) begin
                    w_state_next   = SEND_FWD;
                    w_pop[SRC_FWD] = 1'b1;
                end else if (w_has_pkt[SRC_LOCAL]) begin
                    w_state_next     = SEND_LOCAL;
                    w_pop[SRC_LOCAL] = 1'b1;
                end
            end
            SEND_FWD: begin
                if (w_accept) begin
                    if (r_last) w_state_next   = IDLE;
                    else        w_pop[SRC_FWD] = 1'b1;
                end
            end
            SEND_LOCAL: begin
                if (w_accept) begin
                    if (r_last) w_state_next     = IDLE;
                    else        w_pop[SRC_LOCAL] = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Single output register: holds while stalled, reloads from the granted FIFO on each pop.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid            <= 1'b0;
            r_last             <= 1'b0;
            r_data             <= '0;
            r_last_grant_local <= 1'b1;
        end else begin
            if (w_pop[SRC_FWD]) begin
                r_valid <= 1'b1;
                r_data  <= w_head_data[SRC_FWD];
                r_last  <= w_head_last[SRC_FWD];
            end else if (w_pop[SRC_LOCAL]) begin
                r_valid <= 1'b1;
                r_data  <= w_head_data[SRC_LOCAL];
                r_last  <= w_head_last[SRC_LOCAL];
            end else if (w_accept) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
            if (w_accept && r_last) begin
                r_last_grant_local <= (r_state == SEND_LOCAL);
            end
        end
    end

    assign mergedTDATA        = r_data;
    assign mergedTVALID       = r_valid;
    assign mergedTLAST        = r_last;
    assign forwardedDropCount = w_drop_count[SRC_FWD];
    assign localDropCount     = w_drop_count[SRC_LOCAL];
endmodule

// File: tb/tb_cw_packet_merge_arbiter.sv
// Scoreboard bench for cw_packet_merge_arbiter: delivered beats are compared against a queue
// filled while stimulus is driven; scenario tasks add latency, ordering and drop-count checks.
module tb_cw_packet_merge_arbiter;
    localparam int DCW = 16;

    logic           clk = 1'b0;
    logic           aresetn;
    logic [15:0]    fwd_data, loc_data, m_data;
    logic           fwd_valid, fwd_last, loc_valid, loc_last;
    logic           m_valid, m_last, m_ready;
    logic [DCW-1:0] fwd_drops, loc_drops;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [16:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [16:0] prev_beat  = '0;

    always #5 clk = ~clk;

    cw_packet_merge_arbiter #(.ADDR_WIDTH(6), .DROP_COUNT_WIDTH(DCW)) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .forwardedTDATA    (fwd_data),
        .forwardedTVALID   (fwd_valid),
        .forwardedTLAST    (fwd_last),
        .localTDATA        (loc_data),
        .localTVALID       (loc_valid),
        .localTLAST        (loc_last),
        .mergedTDATA       (m_data),
        .mergedTVALID      (m_valid),
        .mergedTLAST       (m_last),
        .mergedTREADY      (m_ready),
        .forwardedDropCount(fwd_drops),
        .localDropCount    (loc_drops)
    );

    // Monitor: looks at the beat presented for the coming rising edge.
    always begin
        @(negedge clk);
        #1;
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_tests++;
                if (m_valid !== 1'b1 || {m_last, m_data} !== prev_beat) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%b beat=%h, want valid=1 beat=%h",
                             m_valid, {m_last, m_data}, prev_beat);
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got beat=%h, want no beat", {m_last, m_data});
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        n_fail++;
                        $display("FAIL beat_order: got beat=%h, want %h", {m_last, m_data}, e);
                    end
                end
            end
            prev_stall = (m_valid === 1'b1) && (m_ready !== 1'b1);
            prev_beat  = {m_last, m_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic idle_inputs();
        fwd_valid = 1'b0; fwd_last = 1'b0; fwd_data = '0;
        loc_valid = 1'b0; loc_last = 1'b0; loc_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn = 1'b0;
        idle_inputs();
        exp_q.delete();
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
    endtask

    // Drives one packet; returns on the falling edge after its last beat was captured.
    task automatic send_pkt(input bit to_local, input logic [15:0] base, input int len,
                            input bit expect_out);
        for (int i = 0; i < len; i++) begin
            logic [15:0] d;
            logic        l;
            d = base + 16'(i);
            l = (i == len - 1);
            @(negedge clk);
            if (to_local) begin
                loc_valid = 1'b1; loc_data = d; loc_last = l;
            end else begin
                fwd_valid = 1'b1; fwd_data = d; fwd_last = l;
            end
            if (expect_out) exp_q.push_back({l, d});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    // Drives one packet on each source in the same cycles; expectations follow fwd_first.
    task automatic send_pair(input logic [15:0] fbase, input logic [15:0] lbase, input int len,
                             input bit fwd_first);
        logic [16:0] f_beats[$];
        logic [16:0] l_beats[$];
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            fwd_valid = 1'b1; fwd_data = fbase + 16'(i); fwd_last = (i == len - 1);
            loc_valid = 1'b1; loc_data = lbase + 16'(i); loc_last = (i == len - 1);
            f_beats.push_back({fwd_last, fwd_data});
            l_beats.push_back({loc_last, loc_data});
        end
        @(negedge clk);
        idle_inputs();
        if (fwd_first) begin
            foreach (f_beats[i]) exp_q.push_back(f_beats[i]);
            foreach (l_beats[i]) exp_q.push_back(l_beats[i]);
        end else begin
            foreach (l_beats[i]) exp_q.push_back(l_beats[i]);
            foreach (f_beats[i]) exp_q.push_back(f_beats[i]);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || m_valid === 1'b1) && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0 || m_valid === 1'b1) begin
            n_fail++;
            $display("FAIL %s: drain timeout, got %0d beats pending valid=%b, want 0 pending valid=0",
                     name, exp_q.size(), m_valid);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        m_ready = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(m_valid), 32'd0);
        chk("reset_last", 32'(m_last), 32'd0);
        chk("reset_data", 32'(m_data), 32'd0);
        chk("reset_fwd_drops", 32'(fwd_drops), 32'd0);
        chk("reset_loc_drops", 32'(loc_drops), 32'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_valid", 32'(m_valid), 32'd0);
    endtask

    task automatic test_single_local();
        send_pkt(1'b1, 16'h1001, 5, 1'b1);
        chk("lat_n_plus_1_valid", 32'(m_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stream_valid", 32'(m_valid), 32'd1);
            chk("stream_data", 32'(m_data), 32'(16'h1001 + 16'(i)));
            chk("stream_last", 32'(m_last), 32'(i == 4));
        end
        @(negedge clk);
        chk("after_pkt_valid", 32'(m_valid), 32'd0);
        wait_drain("single_local", 20);
        chk("single_fwd_drops", 32'(fwd_drops), 32'd0);
        chk("single_loc_drops", 32'(loc_drops), 32'd0);
    endtask

    task automatic pair_timing(input string name, input logic [15:0] first_base,
                               input logic [15:0] second_base);
        chk({name, "_commit_valid"}, 32'(m_valid), 32'd0);
        @(negedge clk);
        chk({name, "_first_word"}, 32'(m_data), 32'(first_base));
        repeat (4) @(negedge clk);
        chk({name, "_bubble"}, 32'(m_valid), 32'd0);
        @(negedge clk);
        chk({name, "_second_valid"}, 32'(m_valid), 32'd1);
        chk({name, "_second_word"}, 32'(m_data), 32'(second_base));
        wait_drain(name, 30);
    endtask

    task automatic test_round_robin();
        do_reset();
        send_pair(16'h2001, 16'h3001, 4, 1'b1);
        pair_timing("rr_fwd_first", 16'h2001, 16'h3001);
        // A lone forwarded packet leaves lastGrant at FORWARDED, so the next tie goes to local.
        send_pkt(1'b0, 16'h2101, 2, 1'b1);
        wait_drain("rr_lone_fwd", 20);
        send_pair(16'h2201, 16'h3201, 4, 1'b0);
        pair_timing("rr_local_first", 16'h3201, 16'h2201);
    endtask

    task automatic test_backpressure();
        send_pkt(1'b0, 16'h4001, 8, 1'b1);
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            m_ready = (k % 3 == 0);
        end
        @(negedge clk);
        m_ready = 1'b1;
        wait_drain("backpressure", 20);
    endtask

    task automatic test_oversize_drop();
        send_pkt(1'b0, 16'hA000, 70, 1'b0);
        chk("oversize_fwd_drops", 32'(fwd_drops), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("oversize_no_output", 32'(m_valid), 32'd0);
        end
        send_pkt(1'b0, 16'h5001, 3, 1'b1);
        wait_drain("after_oversize", 20);
        chk("after_oversize_fwd_drops", 32'(fwd_drops), 32'd1);
        chk("after_oversize_loc_drops", 32'(loc_drops), 32'd0);
    endtask

    task automatic test_full_drop_saturate();
        m_ready = 1'b0;
        send_pkt(1'b1, 16'h6001, 40, 1'b1);
        send_pkt(1'b1, 16'h7001, 30, 1'b0);
        chk("full_loc_drops", 32'(loc_drops), 32'd1);
        @(negedge clk);
        force dut.g_fifo[1].r_drop_count = 16'hFFFE;
        #1;
        release dut.g_fifo[1].r_drop_count;
        send_pkt(1'b1, 16'h7101, 30, 1'b0);
        chk("sat_reach_max", 32'(loc_drops), 32'h0000_FFFF);
        send_pkt(1'b1, 16'h7201, 30, 1'b0);
        chk("sat_hold_max", 32'(loc_drops), 32'h0000_FFFF);
        @(negedge clk);
        m_ready = 1'b1;
        wait_drain("first_pkt_intact", 100);
    endtask

    task automatic test_reset_mid_packet();
        send_pkt(1'b0, 16'h8001, 10, 1'b1);
        repeat (3) @(negedge clk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("midreset_valid", 32'(m_valid), 32'd0);
        chk("midreset_last", 32'(m_last), 32'd0);
        chk("midreset_fwd_drops", 32'(fwd_drops), 32'd0);
        chk("midreset_loc_drops", 32'(loc_drops), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        chk("postreset_idle", 32'(m_valid), 32'd0);
        send_pkt(1'b1, 16'h9001, 2, 1'b1);
        wait_drain("postreset_pkt", 20);
    endtask

    initial begin
        test_reset();
        test_single_local();
        test_round_robin();
        test_backpressure();
        test_oversize_drop();
        test_full_drop_saturate();
        test_reset_mid_packet();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
